// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: shares the SDRAM command/address bus between init, refresh, write and read engines.
// Refresh always wins; define SDRAM_ARB_RR_EN for round-robin write/read, otherwise write beats read.
module sdram_cmd_arbiter #(
    parameter int AREF_WAIT_MAX = 600,
    parameter int WAIT_W        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic        dq_oe,
    output logic [4:0]  state,
    output logic        aref_late
);
    localparam logic [4:0] IDLE  = 5'b00001;
    localparam logic [4:0] ARBIT = 5'b00010;
    localparam logic [4:0] AREF  = 5'b00100;
    localparam logic [4:0] WRITE = 5'b01000;
    localparam logic [4:0] READ  = 5'b10000;
    localparam logic [3:0] NOP   = 4'b0111;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(AREF_WAIT_MAX);

    logic [4:0]        next_state;
    logic              last_rw;
    logic              pick_wr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    // last_rw is 1 when the most recent data grant was a write
`ifdef SDRAM_ARB_RR_EN
    assign pick_wr = wr_req && (!rd_req || !last_rw);
`else
    assign pick_wr = wr_req | (last_rw & 1'b0);
`endif

    assign wait_nxt = (!aref_req || state == AREF || next_state == AREF) ? '0 :
                      (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            last_rw   <= 1'b0;
            wait_cnt  <= '0;
            aref_late <= 1'b0;
        end else begin
            state     <= next_state;
            aref_en   <= next_state == AREF;
            wr_en     <= next_state == WRITE;
            rd_en     <= next_state == READ;
            if (state == ARBIT && (next_state == WRITE || next_state == READ))
                last_rw <= next_state == WRITE;
            wait_cnt  <= wait_nxt;
            aref_late <= aref_late | (wait_nxt > WAIT_LIM);
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = init_end ? ARBIT : IDLE;
            ARBIT:   next_state = aref_req ? AREF : pick_wr ? WRITE : rd_req ? READ : ARBIT;
            AREF:    next_state = aref_end ? ARBIT : AREF;
            WRITE:   next_state = wr_end ? ARBIT : WRITE;
            READ:    next_state = rd_end ? ARBIT : READ;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sdram_cmd  = NOP;
        sdram_addr = '0;
        dq_oe      = state == WRITE;
        case (state)
            IDLE:    begin sdram_cmd = init_cmd; sdram_addr = init_addr; end
            AREF:    begin sdram_cmd = aref_cmd; sdram_addr = aref_addr; end
            WRITE:   begin sdram_cmd = wr_cmd;   sdram_addr = wr_addr;   end
            READ:    begin sdram_cmd = rd_cmd;   sdram_addr = rd_addr;   end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb_sdram_cmd_arbiter: scoreboard bench for sdram_cmd_arbiter; expected grant order is queued
// when requests are driven and popped as grants appear.
module tb_sdram_cmd_arbiter;
    localparam logic [4:0] IDLE  = 5'b00001;
    localparam logic [4:0] ARBIT = 5'b00010;
    localparam logic [4:0] AREF  = 5'b00100;
    localparam logic [4:0] WRITE = 5'b01000;
    localparam logic [4:0] READ  = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic        aref_en, wr_en, rd_en, dq_oe, aref_late;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [4:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_on = 1'b0;
    logic [4:0] exp_q[$];

    sdram_cmd_arbiter dut (
        .clk(clk), .rst(rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .dq_oe(dq_oe), .state(state), .aref_late(aref_late)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // grants and DQ enable must always track the one-hot state
    always @(negedge clk)
        if (mon_on)
            chk("en_vs_state", {28'd0, aref_en, wr_en, rd_en, dq_oe},
                {28'd0, state == AREF, state == WRITE, state == READ, state == WRITE});

    task automatic do_init();
        repeat (3) step();
        rst = 1'b0;
        step();
        init_end = 1'b1;
        step();
        init_end = 1'b0;
        chk("reinit_arbit", state, ARBIT);
    endtask

    task automatic serve();
        logic [4:0] exp_s;
        int n;
        n = 0;
        while (!(aref_en | wr_en | rd_en) && n < 10) begin
            step();
            n++;
        end
        if (n >= 10) chk("grant_timeout", 0, 1);
        exp_s = exp_q.pop_front();
        chk("grant_order", state, exp_s);
        if (exp_q.size() == 0) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        repeat (3) step();
        wr_end = state == WRITE;
        rd_end = state == READ;
        step();
        wr_end = 1'b0;
        rd_end = 1'b0;
        chk("grant_release", state, ARBIT);
    endtask

    initial begin
        rst = 1'b1;
        {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = '0;
        init_cmd = 4'b0010; init_addr = 13'h0400;
        aref_cmd = 4'b0001; aref_addr = 13'h0aaa;
        wr_cmd   = 4'b0100; wr_addr   = 13'h1234;
        rd_cmd   = 4'b0101; rd_addr   = 13'h0555;
        repeat (5) step();
        rst = 1'b0;
        mon_on = 1'b1;
        chk("rst_state", state, IDLE);
        chk("rst_en", {aref_en, wr_en, rd_en}, 0);
        chk("rst_late", aref_late, 0);
        wr_req = 1'b1; rd_req = 1'b1; aref_req = 1'b1;
        repeat (14) step();
        chk("idle_ignores_req", state, IDLE);
        chk("idle_cmd", sdram_cmd, init_cmd);
        chk("idle_addr", sdram_addr, init_addr);
        {wr_req, rd_req, aref_req} = '0;
        init_end = 1'b1;
        step();
        init_end = 1'b0;
        chk("arbit_state", state, ARBIT);
        chk("arbit_cmd", sdram_cmd, 4'b0111);
        chk("arbit_addr", sdram_addr, 0);
        step();
        chk("arbit_stays", state, ARBIT);

        aref_req = 1'b1; wr_req = 1'b1;
        step();
        aref_req = 1'b0;
        chk("aref_wins", state, AREF);
        chk("aref_en", aref_en, 1);
        chk("wr_blocked", wr_en, 0);
        chk("aref_cmd", sdram_cmd, aref_cmd);
        chk("aref_addr", sdram_addr, aref_addr);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk("foreign_end_ignored", state, AREF);
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        chk("aref_release", state, ARBIT);
        chk("aref_en_drop", aref_en, 0);
        step();
        wr_req = 1'b0;
        chk("wr_after_aref", state, WRITE);
        chk("wr_en", wr_en, 1);
        chk("dq_oe_write", dq_oe, 1);
        chk("wr_cmd", sdram_cmd, wr_cmd);
        chk("wr_addr", sdram_addr, wr_addr);
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk("rd_end_ignored", state, WRITE);
        chk("rd_end_wr_en", wr_en, 1);
        chk("rd_end_rd_en", rd_en, 0);

        #3 rst = 1'b1;
        #1;
        chk("async_rst_state", state, IDLE);
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_dq_oe", dq_oe, 0);
        do_init();

`ifdef SDRAM_ARB_RR_EN
        exp_q.push_back(WRITE); exp_q.push_back(READ);
        exp_q.push_back(WRITE); exp_q.push_back(READ);
`else
        repeat (4) exp_q.push_back(WRITE);
`endif
        wr_req = 1'b1; rd_req = 1'b1;
        repeat (4) serve();
        chk("queue_drained", exp_q.size(), 0);

        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("rd_single", state, READ);
        chk("rd_cmd", sdram_cmd, rd_cmd);
        chk("rd_addr", sdram_addr, rd_addr);
        chk("dq_oe_read", dq_oe, 0);
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk("rd_release", state, ARBIT);

        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        chk("long_write", state, WRITE);
        aref_req = 1'b1;
        repeat (600) step();
        chk("late_not_yet", aref_late, 0);
        step();
        chk("late_set", aref_late, 1);
        repeat (97) step();
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk("long_write_end", state, ARBIT);
        step();
        chk("late_aref_grant", state, AREF);
        aref_req = 1'b0;
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        chk("late_aref_release", state, ARBIT);
        repeat (3) step();
        chk("late_sticky", aref_late, 1);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
